aes_key_loader: RTL
===================

Name: aes_key_loader

Overview:
- Consumer of the EX/MEM pipeline register's AES key-write fields: AES_W, enable_AES, key_size, w3, plus1, mode_aes.
- Assembles 4, 6 or 8 key words written by the pipeline into one key buffer.
- Presents the completed key to the AES core over a valid/ready handshake.
- Asserts a stall to the pipeline while a completed key is waiting to be consumed.

Parameters:
- WORD_W, 32, width of one key word.
- MAX_NK, 8, maximum key words held (AES-256).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pipeline advance; write fields valid only when high.
- aes_w_in  in  1  key-word write strobe from the stage register.
- enable_aes_in  in  1  AES instruction qualifier.
- key_size_in  in  2  key size: 00=128, 01=192, 10=256, 11=reserved.
- mode_aes_in  in  2  AES mode, latched with first word.
- plus1_in  in  1  0 = first word of a new key; 1 = next word.
- w3_in  in  WORD_W  key word data.
- key_out  out  MAX_NK*WORD_W  assembled key; word 0 in bits [255:224].
- key_size_out  out  2  latched key size.
- mode_aes_out  out  2  latched mode.
- key_valid  out  1  key complete, held until accepted.
- key_ready  in  1  AES core accepts key.
- stall_out  out  1  hold pipeline while key_valid.
- overrun  out  1  sticky: write dropped while PRESENT, or reserved key_size.
- word_idx  out  3  next word index, debug.

Behaviour:
- Reset (asynchronous, active-low): every output is 0; buffer zeroed; state IDLE.
- Write event: start && aes_w_in && enable_aes_in in a cycle. With start low, nothing is sampled (bubble).
- Nk: 4 / 6 / 8 for key_size 00 / 01 / 10.
- State IDLE:
  - Write with plus1_in=0 and valid key_size: buffer cleared, w3_in stored at word 0, key_size and mode latched, word_idx=1, go to COLLECT.
  - Write with plus1_in=1: ignored.
- State COLLECT:
  - Write with plus1_in=1: store at word_idx, then word_idx+1.
  - When the stored word is index Nk-1: go to PRESENT next cycle. key_valid and stall_out rise on the edge after that final write (1-cycle latency).
  - Write with plus1_in=0: restart exactly as from IDLE; the partial key is discarded.
  - key_size_in and mode_aes_in are ignored after the first word.
- State PRESENT:
  - key_valid=1, stall_out=1; key_out is stable.
  - Any write event is dropped and sets overrun.
  - Handshake: key_valid && key_ready → IDLE; key_valid and stall_out clear on the same edge.
  - key_ready is ignored outside PRESENT.
- Reserved key_size (11) on a first word: write dropped, overrun set, state unchanged.
- Unused buffer words (index ≥ Nk) read as zero.
- word_idx never exceeds Nk; no wrap.
- overrun clears only on reset.
- Reset mid-operation: immediate return to IDLE, buffer zeroed, any pending key lost.

Optional Feature:
- Macro: AES_KEY_CLEAR_EN.
- Defined: on handshake completion the buffer and key_out are zeroed in the same edge that leaves PRESENT (key hygiene).
- Undefined: key_out retains the last key until the next first-word write clears it.

Decomposition:
- Package aes_key_pkg:
  - Key-size encodings KS_128/KS_192/KS_256/KS_RSVD.
  - NK_128=4, NK_192=6, NK_256=8.
  - State enum IDLE/COLLECT/PRESENT.
  - Function nk_of(key_size).
- No sub-module; a single FSM plus word-indexed buffer.

Test Plan:
- AES-128 load: words 0x2B7E1516, 0x28AED2A6, 0xABF71588, 0x09CF4F3C (plus1=0,1,1,1) → key_valid high 1 cycle after the 4th write; key_out[255:128] equals the words in order, low half 0; stall_out=1.
- AES-256: 8 words 0x00010203..0x1C1D1E1F, key_ready held low 5 cycles → key_valid/stall held and key_out stable; key_ready=1 → key_valid=0 next edge, state IDLE.
- Restart mid-collect: 3 AES-192 words, then plus1=0 with 0xDEADBEEF → word 0=0xDEADBEEF, word_idx=1, words 1..7=0.
- Write while PRESENT, and reserved key_size=11 first word → write dropped, overrun=1, key_out unchanged.
- start=0 with aes_w_in=1 → no state change. Reset asserted during COLLECT → all outputs 0.
- AES_KEY_CLEAR_EN builds: after handshake, key_out=0. Without the macro: key_out retains the value.

Source files
------------

// File: rtl/aes_key_pkg.sv
// Shared encodings and helpers for the AES key loader.
package aes_key_pkg;

  localparam logic [1:0] KS_128  = 2'b00;
  localparam logic [1:0] KS_192  = 2'b01;
  localparam logic [1:0] KS_256  = 2'b10;
  localparam logic [1:0] KS_RSVD = 2'b11;

  localparam int NK_128 = 4;
  localparam int NK_192 = 6;
  localparam int NK_256 = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_t;

  // Number of 32-bit key words for a key-size code; 0 for the reserved code.
  function automatic logic [3:0] nk_of(input logic [1:0] ks);
    case (ks)
      KS_128:  nk_of = 4'(NK_128);
      KS_192:  nk_of = 4'(NK_192);
      KS_256:  nk_of = 4'(NK_256);
      default: nk_of = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_loader.sv
// AES key loader: collects 4/6/8 key words written from the EX/MEM stage into
// one buffer, then offers the finished key to the AES core over valid/ready
// while stalling the pipeline.
// Optional macro AES_KEY_CLEAR_EN: zero the key buffer when the core accepts it.
module aes_key_loader
  import aes_key_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int MAX_NK = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       aes_w_in,
  input  logic                       enable_aes_in,
  input  logic [1:0]                 key_size_in,
  input  logic [1:0]                 mode_aes_in,
  input  logic                       plus1_in,
  input  logic [WORD_W-1:0]          w3_in,
  output logic [MAX_NK*WORD_W-1:0]   key_out,
  output logic [1:0]                 key_size_out,
  output logic [1:0]                 mode_aes_out,
  output logic                       key_valid,
  input  logic                       key_ready,
  output logic                       stall_out,
  output logic                       overrun,
  output logic [2:0]                 word_idx
);

  localparam int IDXW = $clog2(MAX_NK + 1);

  state_t                         r_state;
  // Word 0 lives at the top index so the flattened key has word 0 in the MSBs.
  logic [MAX_NK-1:0][WORD_W-1:0]  r_buf;
  logic [IDXW-1:0]                r_idx;
  logic [IDXW-1:0]                r_nk;
  logic [1:0]                     r_ks;
  logic [1:0]                     r_mode;
  logic                           r_valid;
  logic                           r_ovr;

  logic                           w_wr;
  logic                           w_rsvd;
  logic                           w_first;
  logic [IDXW-1:0]                w_idx_nx;

  assign w_wr     = start & aes_w_in & enable_aes_in;
  assign w_rsvd   = (key_size_in == KS_RSVD);
  assign w_first  = w_wr & ~plus1_in & (r_state != PRESENT);
  assign w_idx_nx = r_idx + 1'b1;

  assign key_out      = r_buf;
  assign key_size_out = r_ks;
  assign mode_aes_out = r_mode;
  assign key_valid    = r_valid;
  assign stall_out    = r_valid;
  assign overrun      = r_ovr;
  // Internal index can reach MAX_NK; the 3-bit debug view saturates instead of wrapping.
  assign word_idx     = (r_idx > IDXW'(7)) ? 3'd7 : r_idx[2:0];

  // Key collection FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_idx   <= '0;
      r_nk    <= '0;
      r_ks    <= '0;
      r_mode  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, COLLECT: begin
          if (w_first) begin
            if (w_rsvd) begin
              r_ovr <= 1'b1;
            end else begin
              // A first word always starts a fresh key, discarding any partial one.
              r_buf           <= '0;
              r_buf[MAX_NK-1] <= w3_in;
              r_idx           <= IDXW'(1);
              r_nk            <= IDXW'(nk_of(key_size_in));
              r_ks            <= key_size_in;
              r_mode          <= mode_aes_in;
              r_state         <= COLLECT;
            end
          end else if (w_wr && plus1_in && (r_state == COLLECT)) begin
            for (int i = 0; i < MAX_NK; i++) begin
              if (r_idx == IDXW'(i)) r_buf[MAX_NK-1-i] <= w3_in;
            end
            r_idx <= w_idx_nx;
            if (w_idx_nx == r_nk) begin
              r_state <= PRESENT;
              r_valid <= 1'b1;
            end
          end
        end
        PRESENT: begin
          if (w_wr) r_ovr <= 1'b1;
          if (key_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_idx   <= '0;
`ifdef AES_KEY_CLEAR_EN
            r_buf   <= '0;
`else
            r_buf   <= r_buf;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
